// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//   - Instruction field positions (opc, funct3, funct7).
//   - fetch_state_t: RUN / HALT.
//   - fetch_entry_t: buffered instruction word plus its fetch address.
//   - sat_add32: saturating 32-bit add used by the optional statistics
//     counters (FETCH_STATS_EN).
package fetch_pkg;

    localparam int unsigned OPC_LSB    = 0;
    localparam int unsigned OPC_MSB    = 6;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_MSB = 14;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_MSB = 31;

    localparam int unsigned INST_W     = 32;
    // Widest PC an entry can carry; narrower XLEN values are zero-extended.
    localparam int unsigned ENTRY_PC_W = 64;
    // Responses still owed to a flushed path; holds several redirects' worth.
    localparam int unsigned DROP_CNT_W = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0]     inst;
        logic [ENTRY_PC_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t, registered (no bypass).
//   clk, rst_n   clock, asynchronous active-low reset
//   push/entry   write one entry (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   flush        discard all entries; takes priority over push and pop
//   head         current head entry
//   empty        no entries held
//   count        number of entries held (0..FIFO_DEPTH)
// FIFO_DEPTH must be a power of two, minimum 2.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     entry,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [FIFO_DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             full;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[PTR_W-1:0]] <= entry;
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Owns the PC, issues in-order word-aligned requests over a valid/ready
// interface, buffers returned words with their PCs and presents decoded fields.
// A redirect flushes the buffer and discards responses still owed to the old
// path; hlt stops fetching permanently (until reset) while buffered words
// stay poppable.
//   imem_req_*    request channel (valid/ready/addr)
//   imem_rsp_*    response channel (in order, no backpressure)
//   inst_*        buffered instruction to the consumer (valid/ready, word, pc)
//   opc/funct3/funct7  fields of inst
//   redirect_*    taken branch/jump target
//   hlt / halted  halt request / fetch stopped
// Optional: define FETCH_STATS_EN to add stat_fetched and stat_dropped,
// saturating counts of pushed instructions and of discarded responses plus
// flushed buffer entries.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opc,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            hlt,
    output logic            halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_dropped
`endif
);

    localparam int unsigned     CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_t            state_q, state_d;
    logic [XLEN-1:0]         pc_q, pc_d;
    logic [CNT_W-1:0]        outst_q, outst_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;

    logic                    fifo_push, fifo_pop, fifo_flush, fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    fetch_entry_t            fifo_entry, fifo_head;

    logic                    credit_ok, req_accept, rsp_drop, rsp_take;
    logic                    redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Each accepted request owns a buffer slot until its word is popped.
    assign credit_ok  = ({1'b0, outst_q} + {1'b0, fifo_count}) < DEPTH_V;
    // Gated with rst_n so the request is low while reset is held and rises in
    // the first cycle after release, without waiting an extra clock.
    assign imem_req_valid = rst_n && (state_q == RUN) && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_accept     = imem_req_valid && imem_req_ready;

    // Responses pay off old-path debt first; responses with nothing owed
    // (stale after reset) are ignored.
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_take = imem_rsp_valid && (drop_q == '0) && (outst_q != '0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (req_accept) pc_d = pc_q + XLEN'(4);
                if (rsp_drop)   drop_d = drop_q - DROP_CNT_W'(1);
                if (!hlt && redirect_valid) begin
                    pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
                    fifo_flush = 1'b1;
                    // Everything in flight, plus a request accepted now, is
                    // wrong-path; the response landing this cycle is already paid.
                    drop_d  = drop_q + DROP_CNT_W'(outst_q) + DROP_CNT_W'(req_accept)
                            - DROP_CNT_W'(rsp_drop) - DROP_CNT_W'(rsp_take);
                    outst_d = '0;
                end else begin
                    fifo_push = rsp_take;
                    outst_d   = outst_q + CNT_W'(req_accept) - CNT_W'(rsp_take);
                    if (hlt) state_d = HALT;
                end
            end
            HALT: begin
                if (rsp_drop)      drop_d  = drop_q - DROP_CNT_W'(1);
                else if (rsp_take) outst_d = outst_q - CNT_W'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    assign fifo_entry.inst = imem_rsp_data;
    assign fifo_entry.pc   = ENTRY_PC_W'(pc_shadow_pc());
    assign fifo_pop        = inst_valid && inst_ready;

    // The word arriving now belongs to the oldest outstanding request, whose
    // address is the current PC minus four per outstanding request.
    function automatic logic [XLEN-1:0] pc_shadow_pc();
        return pc_q - (XLEN'(outst_q) << 2);
    endfunction

    fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .entry (fifo_entry),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .head  (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    if (XLEN < ENTRY_PC_W) begin : g_pc_pad
        logic pc_pad_unused;
        assign pc_pad_unused = ^fifo_head.pc[ENTRY_PC_W-1:XLEN];
    end

    assign inst_valid = !fifo_empty;
    assign inst       = fifo_head.inst;
    assign inst_pc    = fifo_head.pc[XLEN-1:0];
    assign opc        = fifo_head.inst[OPC_MSB:OPC_LSB];
    assign funct3     = fifo_head.inst[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7     = fifo_head.inst[FUNCT7_MSB:FUNCT7_LSB];
    assign halted     = (state_q == HALT);

`ifdef FETCH_STATS_EN
    logic             rsp_discard;
    logic [CNT_W-1:0] flushed_n;

    assign rsp_discard = rsp_drop || (rsp_take && !fifo_push);
    // An entry popped in the flush cycle was consumed, not flushed.
    assign flushed_n   = fifo_flush ? (fifo_count - CNT_W'(fifo_pop)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
        end else begin
            stat_fetched <= sat_add32(stat_fetched, 32'(fifo_push));
            stat_dropped <= sat_add32(stat_dropped, 32'(rsp_discard) + 32'(flushed_n));
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a program-order model.
// The model knows only architectural facts: which address must be fetched
// next, which instruction address the consumer must see next, how many live
// (not flushed) requests are unconsumed, and whether fetch has halted.
module tb_fetch_unit;

    localparam int unsigned     XLEN       = 32;
    localparam logic [31:0]     RESET_PC   = 32'h0000_0000;
    localparam int unsigned     FIFO_DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic [6:0]  opc, funct7;
    logic [2:0]  funct3;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        hlt, halted;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_dropped;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .XLEN      (XLEN),
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .opc           (opc),
        .funct3        (funct3),
        .funct7        (funct7),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .hlt           (hlt),
        .halted        (halted)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched  (stat_fetched),
        .stat_dropped  (stat_dropped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    // Memory returns a word derived from the address so fields are non-trivial.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hF0F0_1013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc = 0;
    int    lat = 1;
    logic  inj_rsp = 1'b0;

    always @(negedge clk) begin
        #1;
        cyc++;
        if (!rst_n) mq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mq[0].addr);
            void'(mq.pop_front());
        end else if (inj_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    end

    // ---------------- model + compare ----------------
    logic [31:0] m_fetch_pc, m_exp_pc, prev_inst, prev_pc;
    int          m_live;
    logic        m_halted, m_flush_next, prev_stall;

    always @(negedge clk) begin
        logic [31:0] w;
        #2;
        if (!rst_n) begin
            chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
            chk("rst_inst_valid", {31'b0, inst_valid}, 0);
            chk("rst_halted", {31'b0, halted}, 0);
            chk("rst_inst", inst, 0);
            chk("rst_inst_pc", inst_pc, 0);
            chk("rst_fields", {7'b0, opc, funct3, funct7}, 0);
            chk("rst_req_addr", imem_req_addr, RESET_PC);
            m_halted     = 1'b0;
            m_fetch_pc   = RESET_PC;
            m_exp_pc     = RESET_PC;
            m_live       = 0;
            m_flush_next = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            chk("halted", {31'b0, halted}, {31'b0, m_halted});
            if (m_flush_next) chk("flush_inst_valid", {31'b0, inst_valid}, 0);
            if (m_halted) chk("halt_req_valid", {31'b0, imem_req_valid}, 0);
            else chk("req_valid", {31'b0, imem_req_valid}, {31'b0, (m_live < FIFO_DEPTH)});
            if (imem_req_valid) chk("req_addr", imem_req_addr, m_fetch_pc);
            if (inst_valid) begin
                w = word_of(m_exp_pc);
                chk("inst_pc", inst_pc, m_exp_pc);
                chk("inst", inst, w);
                chk("opc", {25'b0, opc}, {25'b0, w[6:0]});
                chk("funct3", {29'b0, funct3}, {29'b0, w[14:12]});
                chk("funct7", {25'b0, funct7}, {25'b0, w[31:25]});
            end
            if (prev_stall) begin
                chk("stall_valid", {31'b0, inst_valid}, 1);
                chk("stall_inst", inst, prev_inst);
                chk("stall_pc", inst_pc, prev_pc);
            end
            n_checks++;
            assert (!(dut.fifo_push && !dut.fifo_flush && !dut.fifo_pop &&
                      dut.fifo_count == FIFO_DEPTH))
            else begin
                n_errors++;
                $display("FAIL fifo_overflow: got push into full buffer, expected none");
            end

            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{addr: imem_req_addr, due: cyc + lat});
                m_fetch_pc += 32'd4;
                m_live++;
            end
            if (inst_valid && inst_ready) begin
                m_exp_pc += 32'd4;
                m_live--;
            end
            m_flush_next = 1'b0;
            if (!m_halted && hlt) begin
                m_halted = 1'b1;
            end else if (!m_halted && redirect_valid) begin
                m_fetch_pc   = {redirect_pc[31:2], 2'b00};
                m_exp_pc     = {redirect_pc[31:2], 2'b00};
                m_live       = 0;
                m_flush_next = 1'b1;
            end
            prev_stall = inst_valid && !inst_ready;
            prev_inst  = inst;
            prev_pc    = inst_pc;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max, input string name);
        int n = 0;
        while (!inst_valid && n < max) begin
            tick();
            #3;
            n++;
        end
        if (!inst_valid) chk(name, 0, 1);
    endtask

    task automatic drain();
        tick();
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; hlt = 1'b0;
        repeat (3) tick();

        // Streaming from reset
        tick(); rst_n = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        #3;
        chk("first_req_valid", {31'b0, imem_req_valid}, 1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        wait_valid(10, "first_inst_timeout");
        chk("lit_pc0", inst_pc, 32'h0);
        chk("lit_inst0", inst, 32'hF0F0_1013);
        chk("lit_fields0", {7'b0, opc, funct3, funct7}, {7'b0, 7'h13, 3'd1, 7'h78});
        repeat (12) tick();

        // Consumer stall
        tick(); inst_ready = 1'b0;
        repeat (9) tick();
        #3;
        chk("stall_req_valid", {31'b0, imem_req_valid}, 0);
        chk("stall_inst_valid", {31'b0, inst_valid}, 1);
        tick(); inst_ready = 1'b1;
        repeat (6) tick();

        // Redirect to 0x100 with two requests outstanding
        drain();
        lat = 4;
        tick(); imem_req_ready = 1'b1;
        tick();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h100;
        #3;
        chk("two_out_req_valid", {31'b0, imem_req_valid}, 0);
        chk("two_out_inst_valid", {31'b0, inst_valid}, 0);
        tick(); redirect_valid = 1'b0;
        #3;
        chk("redir_req_addr", imem_req_addr, 32'h100);
        wait_valid(20, "redir_inst_timeout");
        chk("lit_pc100", inst_pc, 32'h100);
        chk("lit_inst100", inst, 32'hF0F0_1113);
`ifdef FETCH_STATS_EN
        chk("stat_dropped", stat_dropped, 32'd2);
`endif

        // Unaligned redirect target
        drain();
        lat = 1;
        tick(); imem_req_ready = 1'b1;
        repeat (4) tick();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick(); redirect_valid = 1'b0;
        #3;
        chk("align_req_valid", {31'b0, imem_req_valid}, 1);
        chk("align_req_addr", imem_req_addr, 32'h100);
        wait_valid(10, "align_inst_timeout");
        chk("align_inst_pc", inst_pc, 32'h100);
        repeat (6) tick();

        // Redirect while an earlier redirect still owes a response
        drain();
        lat = 4;
        tick(); imem_req_ready = 1'b1;
        tick(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h180;
        tick(); redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #3;
        chk("second_req_addr", imem_req_addr, 32'h180);
        tick(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick(); redirect_valid = 1'b0; imem_req_ready = 1'b1;
        wait_valid(30, "second_inst_timeout");
        chk("lit_pc200", inst_pc, 32'h200);
        chk("lit_inst200", inst, 32'hF0F0_1213);
        repeat (4) tick();

        // Halt and redirect together with one buffered entry
        drain();
        lat = 1;
        tick(); imem_req_ready = 1'b1; inst_ready = 1'b0;
        tick(); imem_req_ready = 1'b0;
        tick(); hlt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300; imem_req_ready = 1'b1;
        #3;
        chk("halt_one_buffered", {31'b0, inst_valid}, 1);
        tick(); hlt = 1'b0; redirect_valid = 1'b0;
        #3;
        chk("halt_halted", {31'b0, halted}, 1);
        chk("halt_no_req", {31'b0, imem_req_valid}, 0);
        chk("halt_entry_kept", {31'b0, inst_valid}, 1);
        repeat (3) tick();
        tick(); inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #3;
            chk("halt_no_push", {31'b0, inst_valid}, 0);
            chk("halt_still", {31'b0, halted}, 1);
        end

        // Reset mid-halt; a stale response after release must be ignored
        tick(); rst_n = 1'b0; imem_req_ready = 1'b0;
        tick();
        tick(); rst_n = 1'b1; inj_rsp = 1'b1;
        #3;
        chk("rel_req_valid", {31'b0, imem_req_valid}, 1);
        chk("rel_req_addr", imem_req_addr, RESET_PC);
        tick(); inj_rsp = 1'b0;
        #3;
        chk("stale_ignored", {31'b0, inst_valid}, 0);
        tick(); imem_req_ready = 1'b1;
        wait_valid(10, "rel_inst_timeout");
        chk("rel_inst_pc", inst_pc, RESET_PC);
        repeat (8) tick();

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
